// File: rtl/alu_if.sv
// Operand/result bundle between the register-file read side and the ALU.
// The master drives op, operands and flag_we; the slave returns rd and the flag word.
interface alu_if #(
    parameter int WIDTH    = 16,
    parameter int OP_WIDTH = 4
);
    logic [OP_WIDTH-1:0] op;
    logic [WIDTH-1:0]    rs;
    logic [WIDTH-1:0]    rt;
    logic                flag_we;
    logic [WIDTH-1:0]    rd;
    logic [3:0]          flags;

    modport master (output op, rs, rt, flag_we, input rd, flags);
    modport slave  (input op, rs, rt, flag_we, output rd, flags);
endinterface

// File: rtl/alu.sv
// Integer ALU. rd is combinational (zero latency); {Z,N,C,V} is registered one clk after flag_we; no backpressure.
// ALU_MUL_EN adds the op-11 multiplier; without it op 11 behaves as an unused code.
module alu #(
    parameter int WIDTH    = 16,
    parameter int OP_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_NOT  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_LSL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_LSR  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ASR  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(10);
`ifdef ALU_MUL_EN
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(11);
`endif
    localparam logic [WIDTH:0]      SH_LIM  = (WIDTH+1)'(WIDTH);

    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   sub_x;
    logic [WIDTH:0]   lsl_x;
    logic [WIDTH:0]   lsr_x;
    logic [WIDTH:0]   asr_x;
    logic             sh_ok;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, bus.rs} * {{WIDTH{1'b0}}, bus.rt};
`endif

    // Shifts carry one guard bit so the last bit shifted out falls into it.
    assign add_x = {1'b0, bus.rs} + {1'b0, bus.rt};
    assign sub_x = {1'b0, bus.rs} + {1'b0, ~bus.rt} + (WIDTH+1)'(1);
    assign lsl_x = {1'b0, bus.rs} << bus.rt;
    assign lsr_x = {bus.rs, 1'b0} >> bus.rt;
    assign asr_x = $unsigned($signed({bus.rs, 1'b0}) >>> bus.rt);
    assign sh_ok = (bus.rt != '0) && ({1'b0, bus.rt} <= SH_LIM);

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res    = add_x[WIDTH-1:0];
                c_flag = add_x[WIDTH];
                v_flag = (bus.rs[WIDTH-1] == bus.rt[WIDTH-1]) &&
                         (add_x[WIDTH-1] != bus.rs[WIDTH-1]);
            end
            OP_SUB: begin
                res    = sub_x[WIDTH-1:0];
                c_flag = sub_x[WIDTH];
                v_flag = (bus.rs[WIDTH-1] != bus.rt[WIDTH-1]) &&
                         (sub_x[WIDTH-1] != bus.rs[WIDTH-1]);
            end
            OP_AND:  res = bus.rs & bus.rt;
            OP_OR:   res = bus.rs | bus.rt;
            OP_XOR:  res = bus.rs ^ bus.rt;
            OP_NOT:  res = ~bus.rs;
            OP_LSL: begin
                res    = lsl_x[WIDTH-1:0];
                c_flag = sh_ok & lsl_x[WIDTH];
            end
            OP_LSR: begin
                res    = lsr_x[WIDTH:1];
                c_flag = sh_ok & lsr_x[0];
            end
            OP_ASR: begin
                res    = asr_x[WIDTH:1];
                c_flag = sh_ok & asr_x[0];
            end
            OP_SLT:  res = WIDTH'($signed(bus.rs) < $signed(bus.rt));
            OP_SLTU: res = WIDTH'(bus.rs < bus.rt);
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res    = prod[WIDTH-1:0];
                c_flag = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
                res    = '0;
                c_flag = 1'b0;
                v_flag = 1'b0;
            end
        endcase
    end

    assign bus.rd = res;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.flags <= 4'b0000;
        end else if (bus.flag_we) begin
            bus.flags <= {(res == '0), res[WIDTH-1], c_flag, v_flag};
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: combinational results checked 10 ns after input change,
// flag word checked 1 ns after the capturing clock edge.
module tb_alu;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_if #(.WIDTH(16), .OP_WIDTH(4)) bus ();

    alu #(.WIDTH(16), .OP_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] rs, input logic [15:0] rt,
                         input logic we);
        bus.op      = op;
        bus.rs      = rs;
        bus.rt      = rt;
        bus.flag_we = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'd0, 16'd0, 16'd0, 1'b0);
        step();
        step();
        check("reset_flags", 32'(bus.flags), 32'h0);
        rst = 1'b0;

        // combinational results
        drive(4'd0, 16'd2, 16'd0, 1'b0);       #10 check("add_2_0", 32'(bus.rd), 32'h2);
        bus.rt = 16'd3;                         #10 check("add_2_3", 32'(bus.rd), 32'h5);
        drive(4'd6, 16'd2, 16'd3, 1'b0);       #10 check("lsl_3", 32'(bus.rd), 32'h10);
        bus.rt = 16'd0;                         #10 check("lsl_0", 32'(bus.rd), 32'h2);
        bus.rt = 16'd16;                        #10 check("lsl_16", 32'(bus.rd), 32'h0);
        drive(4'd7, 16'h8000, 16'd15, 1'b0);   #10 check("lsr_15", 32'(bus.rd), 32'h1);
        bus.rt = 16'd16;                        #10 check("lsr_16", 32'(bus.rd), 32'h0);
        drive(4'd8, 16'h8000, 16'd4, 1'b0);    #10 check("asr_4", 32'(bus.rd), 32'hF800);
        drive(4'd2, 16'hF0F0, 16'hFF00, 1'b0); #10 check("and", 32'(bus.rd), 32'hF000);
        bus.op = 4'd3;                          #10 check("or", 32'(bus.rd), 32'hFFF0);
        bus.op = 4'd4;                          #10 check("xor", 32'(bus.rd), 32'h0FF0);
        bus.op = 4'd5;                          #10 check("not", 32'(bus.rd), 32'h0F0F);
        bus.op = 4'd12;                         #10 check("op12", 32'(bus.rd), 32'h0);
        bus.op = 4'd15;                         #10 check("op15", 32'(bus.rd), 32'h0);
        drive(4'd9, 16'hFFFF, 16'd1, 1'b0);    #10 check("slt", 32'(bus.rd), 32'h1);
        bus.op = 4'd10;                         #10 check("sltu", 32'(bus.rd), 32'h0);

        // flag register
        drive(4'd1, 16'd5, 16'd5, 1'b1);
        step();
        check("sub_eq_flags", 32'(bus.flags), 32'b1010);
        drive(4'd1, 16'd0, 16'd1, 1'b1);
        step();
        check("sub_borrow_rd", 32'(bus.rd), 32'hFFFF);
        check("sub_borrow_flags", 32'(bus.flags), 32'b0100);
        drive(4'd0, 16'h7FFF, 16'd1, 1'b1);
        step();
        check("add_ovf_rd", 32'(bus.rd), 32'h8000);
        check("add_ovf_flags", 32'(bus.flags), 32'b0101);
        drive(4'd0, 16'hFFFF, 16'd1, 1'b1);
        step();
        check("add_carry_flags", 32'(bus.flags), 32'b1010);
        drive(4'd6, 16'h8001, 16'd1, 1'b1);
        step();
        check("lsl1_rd", 32'(bus.rd), 32'h0002);
        check("lsl1_flags", 32'(bus.flags), 32'b0010);
        drive(4'd6, 16'h0001, 16'd16, 1'b1);
        step();
        check("lsl16_flags", 32'(bus.flags), 32'b1010);
        drive(4'd0, 16'd0, 16'd0, 1'b0);
        step();
        check("hold_flags", 32'(bus.flags), 32'b1010);
        drive(4'd7, 16'h0003, 16'd1, 1'b1);
        step();
        check("lsr1_flags", 32'(bus.flags), 32'b0010);
        drive(4'd8, 16'h8000, 16'd20, 1'b1);
        step();
        check("asr20_rd", 32'(bus.rd), 32'hFFFF);
        check("asr20_flags", 32'(bus.flags), 32'b0100);

        // reset beats flag_we, then hold
        rst = 1'b1;
        drive(4'd0, 16'h7FFF, 16'd1, 1'b1);
        step();
        check("rst_prio_flags", 32'(bus.flags), 32'h0);
        rst = 1'b0;
        bus.flag_we = 1'b0;
        step();
        check("rst_hold_flags", 32'(bus.flags), 32'h0);

        drive(4'd12, 16'h1234, 16'h5678, 1'b1);
        step();
        check("op12_flags", 32'(bus.flags), 32'b1000);

        // multiplier
        drive(4'd11, 16'd3, 16'd7, 1'b1);
        step();
`ifdef ALU_MUL_EN
        check("mul_rd", 32'(bus.rd), 32'd21);
        check("mul_flags", 32'(bus.flags), 32'b0000);
`else
        check("mul_rd", 32'(bus.rd), 32'd0);
        check("mul_flags", 32'(bus.flags), 32'b1000);
`endif
        drive(4'd11, 16'h0100, 16'h0100, 1'b1);
        step();
`ifdef ALU_MUL_EN
        check("mul_hi_flags", 32'(bus.flags), 32'b1010);
`else
        check("mul_hi_flags", 32'(bus.flags), 32'b1000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
